// File: rtl/pbit_sample_averager.sv
// rtl/pbit_sample_averager.sv - per-bit ones counter with burn-in discard and majority vote
module pbit_sample_averager #(
  parameter int N_BITS = 5,
  parameter int CNT_W  = 16,
  parameter int BURN_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        window,
  input  logic [BURN_W-1:0]       burn_in,
  input  logic [N_BITS-1:0]       p_bits,
  output logic                    busy,
  output logic                    done,
  output logic [N_BITS*CNT_W-1:0] sums,
  output logic [N_BITS-1:0]       majority
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BURN = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    win_q;
  logic [CNT_W-1:0]    acc_cnt;
  logic [BURN_W-1:0]   burn_cnt;
  logic [CNT_W-1:0]    sum_q  [N_BITS];
  logic [CNT_W-1:0]    sum_nx [N_BITS];
  logic [N_BITS-1:0]   maj_nx;

  // Majority is taken on the sums including the final sample, compared one bit wider.
  always_comb begin
    for (int i = 0; i < N_BITS; i++) begin
      sum_nx[i] = sum_q[i] + {{(CNT_W-1){1'b0}}, p_bits[i]};
      maj_nx[i] = {sum_nx[i], 1'b0} > {1'b0, win_q};
    end
  end

  always_comb begin
    sums = '0;
    for (int i = 0; i < N_BITS; i++) begin
      sums[i*CNT_W +: CNT_W] = sum_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      majority <= '0;
      win_q    <= '0;
      acc_cnt  <= '0;
      burn_cnt <= '0;
      for (int i = 0; i < N_BITS; i++) sum_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            win_q    <= window;
            acc_cnt  <= window;
            burn_cnt <= burn_in;
            busy     <= 1'b1;
            for (int i = 0; i < N_BITS; i++) sum_q[i] <= '0;
            if (burn_in != '0) begin
              state <= BURN;
            end else if (window != '0) begin
              state <= ACC;
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              majority <= '0;
            end
          end
        end
        BURN: begin
          burn_cnt <= burn_cnt - 1'b1;
          if (burn_cnt == {{(BURN_W-1){1'b0}}, 1'b1}) begin
            if (win_q != '0) begin
              state <= ACC;
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              majority <= '0;
            end
          end
        end
        ACC: begin
          for (int i = 0; i < N_BITS; i++) sum_q[i] <= sum_nx[i];
          acc_cnt <= acc_cnt - 1'b1;
          if (acc_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state    <= DONE;
            done     <= 1'b1;
            majority <= maj_nx;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
